// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_ctrl
// Description : Multi-precision add sequencer driving one shared 16-bit adder,
//               one word per clock, LSW first, carry chained in a register.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_WORDS*WORD_W-1:0] op_a,
  input  logic [NUM_WORDS*WORD_W-1:0] op_b,
  input  logic                        carry_in,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_WORDS*WORD_W-1:0] result,
  output logic                        overflow,
  output logic [WORD_W-1:0]           adder_a,
  output logic [WORD_W-1:0]           adder_b,
  output logic                        adder_cin,
  input  logic [WORD_W-1:0]           adder_sum,
  input  logic                        adder_overflow
);

  localparam int              IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic              overflow_q;
  logic [WORD_W-1:0] a_q      [NUM_WORDS];
  logic [WORD_W-1:0] b_q      [NUM_WORDS];
  logic [WORD_W-1:0] result_q [NUM_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Adder inputs are forced to zero outside ADD so the shared datapath is quiet.
  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_ADD: begin
        busy      = 1'b1;
        adder_a   = a_q[idx_q];
        adder_b   = b_q[idx_q];
        adder_cin = carry_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        a_q[w]      <= '0;
        b_q[w]      <= '0;
        result_q[w] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
              a_q[w] <= op_a[w*WORD_W +: WORD_W];
              b_q[w] <= op_b[w*WORD_W +: WORD_W];
            end
            carry_q <= carry_in;
            idx_q   <= '0;
          end
        end
        S_ADD: begin
          result_q[idx_q] <= adder_sum;
          carry_q         <= adder_overflow;
          if (idx_q == LAST_IDX) begin
            overflow_q <= adder_overflow;
            idx_q      <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_pack
    assign result[w*WORD_W +: WORD_W] = result_q[w];
  end

  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_seq_ctrl
// Description : Scoreboard bench for adder_seq_ctrl (4-word and 2-word builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] op_a, op_b;
  logic        carry_in;
  logic        ready, busy, done, overflow;
  logic [63:0] result;
  logic [15:0] adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_overflow;

  logic        start2;
  logic [31:0] op_a2, op_b2;
  logic        carry_in2;
  logic        ready2, busy2, done2, overflow2;
  logic [31:0] result2;
  logic [15:0] adder_a2, adder_b2, adder_sum2;
  logic        adder_cin2, adder_overflow2;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] sb[$];

  // Behavioural stand-ins for the external combinational adder_16bit.
  assign {adder_overflow, adder_sum}   = {1'b0, adder_a}  + {1'b0, adder_b}  + {16'd0, adder_cin};
  assign {adder_overflow2, adder_sum2} = {1'b0, adder_a2} + {1'b0, adder_b2} + {16'd0, adder_cin2};

  adder_seq_ctrl #(.NUM_WORDS(4), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .ready(ready), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .adder_a(adder_a), .adder_b(adder_b),
    .adder_cin(adder_cin), .adder_sum(adder_sum), .adder_overflow(adder_overflow)
  );

  adder_seq_ctrl #(.NUM_WORDS(2), .WORD_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
    .carry_in(carry_in2), .ready(ready2), .busy(busy2), .done(done2),
    .result(result2), .overflow(overflow2), .adder_a(adder_a2), .adder_b(adder_b2),
    .adder_cin(adder_cin2), .adder_sum(adder_sum2), .adder_overflow(adder_overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        chk("sum", {overflow, result}, e);
      end
    end
  end

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic [64:0] exp);
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    sb.push_back(exp);
    start = 1'b1; op_a = a; op_b = b; carry_in = c;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = ~a; op_b = ~b; carry_in = ~c;
  endtask

  task automatic track(input int n, input bit cin_chk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (cin_chk) chk("adder_cin", adder_cin, 1);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("ready_after", ready, 1);
  endtask

  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [32:0] exp);
    int t = 0;
    @(negedge clk);
    start2 = 1'b1; op_a2 = a; op_b2 = b; carry_in2 = c;
    @(posedge clk);
    #1;
    start2 = 1'b0; op_a2 = '0; op_b2 = '0; carry_in2 = 1'b0;
    while (!done2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("n2_done", done2, 1);
    chk("n2_sum", {overflow2, result2}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
    start2 = 1'b0; op_a2 = '0; op_b2 = '0; carry_in2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", {overflow, result}, 0);
    chk("rst_adder", {adder_a, adder_b, adder_cin}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Carry out of word 0 into word 1
    accept(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 65'h0_0000_0000_0001_0000);
    track(4, 1'b0);

    // Full ripple through every word
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
    track(4, 1'b1);

    // Start held high: second op only accepted NUM_WORDS+2 cycles later
    @(negedge clk);
    sb.push_back({1'b1, 64'h3CC3_0001_5E14_000E});
    start = 1'b1; op_a = 64'hA9BE_0000_7FF1_0005; op_b = 64'h9305_0000_DE23_0008; carry_in = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(65'd13);
    op_a = 64'd5; op_b = 64'd8; carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_ready_low", ready, 0);
    end
    @(negedge clk);
    chk("held_ready_high", ready, 1);
    chk("held_not_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("held_second_accept", busy, 1);
    track(3, 1'b0);

    // Asynchronous reset between edges during ADD
    accept(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 65'h0_3333_3333_3333_3333);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", {overflow, result}, 0);
    chk("arst_adder", {adder_a, adder_b, adder_cin}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after the 2nd ADD edge: op abandoned, then a clean op
    accept(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 65'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_result", {overflow, result}, 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    accept(64'd5, 64'd8, 1'b1, 65'd14);
    track(4, 1'b0);

    // Two-word build
    run2(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0});
    run2(32'h1234_8000, 32'h1111_8000, 1'b1, 33'h0_2346_0001);

    // Random regression against a 65-bit reference sum
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] a, b;
      logic        c;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = 1'($urandom_range(1, 0));
      accept(a, b, c, {1'b0, a} + {1'b0, b} + {64'd0, c});
    end

    begin
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("sb_drain", sb.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer that reuses one external combinational adder_16bit instance to perform a multi-precision add of NUM_WORDS×16-bit operands.
- Processes one 16-bit word per clock, LSW first, chaining the carry through a register.
- Sits between a requesting master (start/ready/done handshake) and the shared adder datapath.

Parameters:
NUM_WORDS, 4, number of 16-bit words per operand; legal range 2..8
WORD_W, 16, adder word width; fixed at 16 to match adder_16bit

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only while ready=1
op_a  in  NUM_WORDS*16  operand A, word 0 = bits [15:0]
op_b  in  NUM_WORDS*16  operand B
carry_in  in  1  carry into word 0
ready  out  1  high in IDLE; start accepted when start & ready
busy  out  1  high in ADD
done  out  1  one-cycle completion pulse
result  out  NUM_WORDS*16  sum
overflow  out  1  carry out of the most-significant word
adder_a  out  16  to adder_16bit .a
adder_b  out  16  to adder_16bit .b
adder_cin  out  1  to adder_16bit .carry_in
adder_sum  in  16  from adder_16bit .sum
adder_overflow  in  1  from adder_16bit .overflow

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, idx=0, carry_reg=0, op regs=0, result=0, overflow=0, done=0, busy=0, ready=1, adder_a/b/cin=0.
  - An in-flight operation is abandoned; no done pulse.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: capture op_a, op_b into a_reg, b_reg; carry_reg<=carry_in; idx<=0; go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - busy=1, ready=0.
  - Adder inputs are driven combinationally from registers: adder_a=a_reg word[idx], adder_b=b_reg word[idx], adder_cin=carry_reg.
  - At each edge: result word[idx]<=adder_sum; carry_reg<=adder_overflow; idx<=idx+1.
  - At the edge where idx=NUM_WORDS-1: overflow<=adder_overflow, idx<=0, go to DONE.
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Next edge returns to IDLE.
- Adder inputs are driven to 0 in IDLE and DONE.
- Latency:
  - done is high in the cycle after the NUM_WORDS-th edge following the accepting edge.
  - Minimum start-to-start period is NUM_WORDS+2 cycles.
- start while busy or in DONE: ignored; it is not queued.
- op_a, op_b and carry_in may change after acceptance without affecting the operation in flight.
- result and overflow:
  - Words of result update progressively during ADD.
  - Final values are valid from the done cycle and hold until the next accepted operation's ADD writes.
- Arithmetic: result and overflow must equal {overflow,result} = op_a + op_b + carry_in, computed at (NUM_WORDS*16+1) bits; any carry beyond that is impossible.
- Timing: adder_16bit is combinational; its propagation delay must fit within one clk period.

Test Plan:
1. Reset check: assert rst mid-simulation, asynchronously, between edges → outputs immediately take their reset values (ready=1, result=0, overflow=0, done=0, busy=0, adder_a/b/cin=0).
2. Word carry (NUM_WORDS=4): op_a=0x0000_0000_0000_FFFF, op_b=0x0000_0000_0000_0001, cin=0 → result=0x0000_0000_0001_0000, overflow=0, done exactly 4 edges after acceptance, busy high 4 cycles.
3. Full ripple: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0, cin=1 → result=0, overflow=1. Also verify adder_cin=1 in every ADD cycle.
4. Large operands: op_a=0xA9BE_0000_7FF1_0005, op_b=0x9305_0000_DE23_0008, cin=1 → result=0x3CC3_0001_5E14_000E, overflow=1. Keep start held high throughout; the next operation is accepted only NUM_WORDS+2 cycles after the first.
5. Reset mid-op: assert rst after the 2nd ADD edge → no done pulse, result=0. A following start with op_a=5, op_b=8, cin=1 completes with result=14, overflow=0.
6. Randomized regression: 1000 random operand pairs and carry_in values, compared against a (NUM_WORDS*16+1)-bit reference sum. Also run with NUM_WORDS=2: 0xFFFF_FFFF+0x0000_0001 → result=0, overflow=1.
